// File: rtl/vec_lane_accumulator.sv
// Per-lane frame accumulator behind the N-lane vector adder: sums beats until in_last or
// MAX_BEATS, then holds the totals on a valid/ready port. Define VEC_ACC_SATURATE_EN to clamp lanes instead of wrapping.
module vec_lane_accumulator #(
    parameter int W         = 8,
    parameter int N         = 4,
    parameter int ACC_W     = 16,
    parameter int MAX_BEATS = 15,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_y [N-1:0],
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum [N-1:0],
    output logic [CW-1:0]    out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg  [N-1:0];
    logic [ACC_W-1:0] acc_next [N-1:0];
    logic [CW-1:0]    count_reg, count_next;
    logic             ovf_reg, ovf_next;

    logic [ACC_W-1:0] lane_sum [N-1:0];
    logic [N-1:0]     carry;
    logic             accept, new_frame, closing;
    logic [CW-1:0]    beat_count;

    // One widened adder per lane; the extra bit is the lane's carry-out.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [ACC_W:0] wide;
        assign wide      = {1'b0, acc_reg[gi]} + (ACC_W + 1)'(in_y[gi]);
        assign carry[gi] = wide[ACC_W];
`ifdef VEC_ACC_SATURATE_EN
        assign lane_sum[gi] = carry[gi] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
        assign lane_sum[gi] = wide[ACC_W-1:0];
`endif
    end

    assign in_ready  = (state_reg != HOLD) || out_ready;
    assign accept    = in_valid && in_ready;
    // IDLE and a draining HOLD both start a fresh frame rather than adding to stale totals.
    assign new_frame = (state_reg != ACCUM);
    assign beat_count = new_frame ? CW'(1) : count_reg + CW'(1);
    assign closing   = in_last || (beat_count == CW'(MAX_BEATS));

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        for (int i = 0; i < N; i++) begin
            acc_next[i] = acc_reg[i];
        end
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                acc_next[i] = new_frame ? ACC_W'(in_y[i]) : lane_sum[i];
            end
            count_next = beat_count;
            ovf_next   = new_frame ? 1'b0 : (ovf_reg | (|carry));
            state_next = closing ? HOLD : ACCUM;
        end else if (state_reg == HOLD && out_ready) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                acc_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            for (int i = 0; i < N; i++) begin
                acc_reg[i] <= acc_next[i];
            end
        end
    end

    // The accumulator registers double as the result registers while in HOLD.
    assign out_valid = (state_reg == HOLD);
    assign out_count = count_reg;
    assign out_ovf   = ovf_reg;
    for (genvar gi = 0; gi < N; gi++) begin : g_out
        assign out_sum[gi] = acc_reg[gi];
    end

endmodule

// File: tb/tb_vec_lane_accumulator.sv
// Bench for vec_lane_accumulator: directed frames plus randomized traffic checked against a
// frame-level model (unbounded integer lane totals, reduced to ACC_W only when a frame closes).
module tb_vec_lane_accumulator;
    localparam int W = 8, N = 4, ACC_W = 16, MAX_BEATS = 15, CW = 4;
    localparam longint MAXV = (64'd1 << ACC_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic             in_valid, in_last, in_ready, out_valid, out_ready, out_ovf;
    logic [W-1:0]     in_y    [N-1:0];
    logic [ACC_W-1:0] out_sum [N-1:0];
    logic [CW-1:0]    out_count;

    vec_lane_accumulator #(.W(W), .N(N), .ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    // Narrow-accumulator instance for the overflow case.
    logic       v9, r9, l9, ov9, o9, or9;
    logic [7:0] y9 [3:0];
    logic [8:0] s9 [3:0];
    logic [3:0] c9;

    vec_lane_accumulator #(.W(8), .N(4), .ACC_W(9), .MAX_BEATS(15)) u_dut9 (
        .clock(clock), .reset(reset),
        .in_valid(v9), .in_ready(r9), .in_y(y9), .in_last(l9),
        .out_valid(ov9), .out_ready(or9),
        .out_sum(s9), .out_count(c9), .out_ovf(o9)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    longint tot [N];
    int     beats;
    bit     pending;
    longint exp_sum [N];
    int     exp_cnt;
    bit     exp_ovf;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [N-1:0][W-1:0] mk(input int a, input int b, input int c, input int d);
        logic [N-1:0][W-1:0] y;
        y[0] = W'(a); y[1] = W'(b); y[2] = W'(c); y[3] = W'(d);
        return y;
    endfunction

    function automatic logic [N-1:0][W-1:0] rnd_y();
        return mk($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255));
    endfunction

    task automatic model_reset();
        beats   = 0;
        pending = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".valid"}, out_valid, pending);
        if (pending) begin
            for (int i = 0; i < N; i++) begin
                check_val($sformatf("%s.sum%0d", tag, i), out_sum[i], exp_sum[i]);
            end
            check_val({tag, ".count"}, out_count, exp_cnt);
            check_val({tag, ".ovf"}, out_ovf, exp_ovf);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, predict, advance to next negedge.
    task automatic step(input bit v, input bit last, input logic [N-1:0][W-1:0] y,
                        input bit ordy, input string tag);
        bit acc;
        check_outputs(tag);
        in_valid  = v;
        in_last   = last;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_y[i] = y[i];
        #1;
        check_val({tag, ".in_ready"}, in_ready, !pending || ordy);
        acc = v && (!pending || ordy);
        if (pending && ordy) pending = 1'b0;
        if (acc) begin
            if (beats == 0) for (int i = 0; i < N; i++) tot[i] = 0;
            for (int i = 0; i < N; i++) tot[i] += longint'(y[i]);
            beats++;
            if (last || beats == MAX_BEATS) begin
                pending = 1'b1;
                exp_cnt = beats;
                exp_ovf = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (tot[i] > MAXV) exp_ovf = 1'b1;
`ifdef VEC_ACC_SATURATE_EN
                    exp_sum[i] = (tot[i] > MAXV) ? MAXV : tot[i];
`else
                    exp_sum[i] = tot[i] % (MAXV + 1);
`endif
                end
                beats = 0;
            end
        end
        $display("[TB] %s v=%0d last=%0d ordy=%0d accepted=%0d pending=%0d", tag, v, last, ordy, acc, pending);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        in_valid = 0; in_last = 0; out_ready = 0;
        for (int i = 0; i < N; i++) in_y[i] = '0;
        v9 = 0; l9 = 0; or9 = 0;
        for (int i = 0; i < 4; i++) y9[i] = '0;
        model_reset();

        repeat (3) @(negedge clock);
        check_val("rst.valid", out_valid, 0);
        check_val("rst.count", out_count, 0);
        check_val("rst.ovf", out_ovf, 0);
        check_val("rst.sum0", out_sum[0], 0);
        reset = 1'b1;
        @(negedge clock);

        // Three-beat frame closed by in_last
        step(1, 0, mk(1, 2, 3, 4), 1, "t1");
        step(1, 0, mk(10, 20, 30, 40), 1, "t1");
        step(1, 1, mk(5, 5, 5, 5), 0, "t1");
        check_val("t1.valid", out_valid, 1);
        check_val("t1.sum0", out_sum[0], 16);
        check_val("t1.sum1", out_sum[1], 27);
        check_val("t1.sum2", out_sum[2], 38);
        check_val("t1.sum3", out_sum[3], 49);
        check_val("t1.count", out_count, 3);
        check_val("t1.ovf", out_ovf, 0);
        step(0, 0, mk(0, 0, 0, 0), 1, "t1.drain");

        // Forced close at MAX_BEATS, then a blocked 16th beat
        for (int k = 0; k < MAX_BEATS; k++) step(1, 0, mk(255, 255, 255, 255), 0, "t2");
        check_val("t2.sum0", out_sum[0], 3825);
        check_val("t2.sum3", out_sum[3], 3825);
        check_val("t2.count", out_count, 15);
        step(1, 0, mk(255, 255, 255, 255), 0, "t2.blocked");
        step(1, 0, mk(255, 255, 255, 255), 1, "t2.drain16");
        step(1, 1, mk(1, 1, 1, 1), 1, "t3.close");

        // Stalled result, then drain with a single-beat frame
        for (int k = 0; k < 5; k++) step(1, 0, rnd_y(), 0, "t3.hold");
        step(1, 1, mk(7, 7, 7, 7), 1, "t3.new");
        check_val("t3.sum0", out_sum[0], 7);
        check_val("t3.count", out_count, 1);
        step(0, 0, mk(0, 0, 0, 0), 1, "t3.drain");

        // Asynchronous reset mid-frame
        step(1, 0, mk(3, 3, 3, 3), 1, "t5");
        step(1, 0, mk(3, 3, 3, 3), 1, "t5");
        #2 reset = 1'b0;
        #1;
        check_val("t5.rst.valid", out_valid, 0);
        check_val("t5.rst.count", out_count, 0);
        check_val("t5.rst.ovf", out_ovf, 0);
        for (int i = 0; i < N; i++) check_val($sformatf("t5.rst.sum%0d", i), out_sum[i], 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        step(1, 1, mk(1, 1, 1, 1), 1, "t5.after");
        check_val("t5.sum0", out_sum[0], 1);
        check_val("t5.count", out_count, 1);

        // Back-to-back single-beat frames
        for (int k = 0; k < 10; k++) step(1, 1, rnd_y(), 1, "t6");

        // Randomized traffic
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, rnd_y(),
                 $urandom_range(0, 9) < 6, "rand");
        check_outputs("final");

        // Nine-bit accumulator overflow
        in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            v9 = 1; l9 = (k == 2); or9 = 0;
            for (int i = 0; i < 4; i++) y9[i] = 8'd255;
            @(posedge clock);
            @(negedge clock);
        end
        v9 = 0;
        check_val("t4.valid", ov9, 1);
        check_val("t4.count", c9, 3);
        check_val("t4.ovf", o9, 1);
`ifdef VEC_ACC_SATURATE_EN
        check_val("t4.sum0", s9[0], 511);
        check_val("t4.sum3", s9[3], 511);
`else
        check_val("t4.sum0", s9[0], 253);
        check_val("t4.sum3", s9[3], 253);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
